// File: rtl/retire_insn_encoder_pkg.sv
// Shared types and constants for the retire-side instruction encoder.
//   opcode_t        : uop operation codes, as carried on the ROB commit port
//   M_WIDTH         : PC width
//   LG_PRF_ENTRIES  : register-index width on the uop (low 5 bits are architectural)
//   OPC_* / CSR_*   : RV32 major opcodes and counter CSR numbers
//   enc_*           : field packers for the RV32 instruction formats
package retire_insn_encoder_pkg;

  localparam int M_WIDTH        = 32;
  localparam int LG_PRF_ENTRIES = 6;

  typedef enum logic [6:0] {
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_LUI, OP_AUIPC,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_J, OP_JALR, OP_JR, OP_RET,
    OP_NOP, OP_BREAK, OP_MONITOR,
    OP_RDCYCLE, OP_RDCYCLEH, OP_RDINSTRET, OP_RDINSTRETH,
    OP_II
  } opcode_t;

  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_OPIMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_OP    = 7'h33;
  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_JAL   = 7'h6f;
  localparam logic [6:0] OPC_SYS   = 7'h73;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [31:0] INSN_NOP     = 32'h0000_0013;
  localparam logic [31:0] INSN_BREAK   = 32'h0000_0073;
  localparam logic [31:0] INSN_MONITOR = 32'h0010_0073;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OPC_BR};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/retire_insn_encoder_pack.sv
// rv_insn_pack: purely combinational re-encoder from a retired uop to its
// canonical RV32IM instruction word.
//   op, rd, rs1, rs2, rvimm, pc : uop fields (register indices already 5 bits)
//   insn                        : encoded word, 0 when bad
//   bad                         : op unknown/illegal or PC-relative offset unencodable
module rv_insn_pack
  import retire_insn_encoder_pkg::*;
(
  input  opcode_t              op,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [31:0]          rvimm,
  input  logic [M_WIDTH-1:0]   pc,
  output logic [31:0]          insn,
  output logic                 bad
);

  logic [31:0] off;
  logic        br_bad;
  logic        jal_bad;
  logic [31:0] word;
  logic        unk;
  logic        range_bad;

  // rvimm carries the absolute target for PC-relative ops; recover the offset.
  assign off = rvimm - 32'(pc);

  // Sign-fit means every bit above the field's sign bit equals it.
  assign br_bad  = ~((&off[31:12]) | ~(|off[31:12])) | off[0];
  assign jal_bad = ~((&off[31:20]) | ~(|off[31:20])) | off[0];

  always_comb begin
    word      = '0;
    unk       = 1'b0;
    range_bad = 1'b0;
    case (op)
      OP_ADDI   : word = enc_i(rvimm[11:0], rs1, 3'b000, rd, OPC_OPIMM);
      OP_SLTI   : word = enc_i(rvimm[11:0], rs1, 3'b010, rd, OPC_OPIMM);
      OP_SLTIU  : word = enc_i(rvimm[11:0], rs1, 3'b011, rd, OPC_OPIMM);
      OP_XORI   : word = enc_i(rvimm[11:0], rs1, 3'b100, rd, OPC_OPIMM);
      OP_ORI    : word = enc_i(rvimm[11:0], rs1, 3'b110, rd, OPC_OPIMM);
      OP_ANDI   : word = enc_i(rvimm[11:0], rs1, 3'b111, rd, OPC_OPIMM);
      OP_SLLI   : word = enc_r(F7_BASE, rvimm[4:0], rs1, 3'b001, rd, OPC_OPIMM);
      OP_SRLI   : word = enc_r(F7_BASE, rvimm[4:0], rs1, 3'b101, rd, OPC_OPIMM);
      OP_SRAI   : word = enc_r(F7_ALT,  rvimm[4:0], rs1, 3'b101, rd, OPC_OPIMM);
      OP_ADD    : word = enc_r(F7_BASE, rs2, rs1, 3'b000, rd, OPC_OP);
      OP_SUB    : word = enc_r(F7_ALT,  rs2, rs1, 3'b000, rd, OPC_OP);
      OP_SLL    : word = enc_r(F7_BASE, rs2, rs1, 3'b001, rd, OPC_OP);
      OP_SLT    : word = enc_r(F7_BASE, rs2, rs1, 3'b010, rd, OPC_OP);
      OP_SLTU   : word = enc_r(F7_BASE, rs2, rs1, 3'b011, rd, OPC_OP);
      OP_XOR    : word = enc_r(F7_BASE, rs2, rs1, 3'b100, rd, OPC_OP);
      OP_SRL    : word = enc_r(F7_BASE, rs2, rs1, 3'b101, rd, OPC_OP);
      OP_SRA    : word = enc_r(F7_ALT,  rs2, rs1, 3'b101, rd, OPC_OP);
      OP_OR     : word = enc_r(F7_BASE, rs2, rs1, 3'b110, rd, OPC_OP);
      OP_AND    : word = enc_r(F7_BASE, rs2, rs1, 3'b111, rd, OPC_OP);
      OP_MUL    : word = enc_r(F7_MULDIV, rs2, rs1, 3'b000, rd, OPC_OP);
      OP_MULH   : word = enc_r(F7_MULDIV, rs2, rs1, 3'b001, rd, OPC_OP);
      OP_MULHSU : word = enc_r(F7_MULDIV, rs2, rs1, 3'b010, rd, OPC_OP);
      OP_MULHU  : word = enc_r(F7_MULDIV, rs2, rs1, 3'b011, rd, OPC_OP);
      OP_DIV    : word = enc_r(F7_MULDIV, rs2, rs1, 3'b100, rd, OPC_OP);
      OP_DIVU   : word = enc_r(F7_MULDIV, rs2, rs1, 3'b101, rd, OPC_OP);
      OP_REM    : word = enc_r(F7_MULDIV, rs2, rs1, 3'b110, rd, OPC_OP);
      OP_REMU   : word = enc_r(F7_MULDIV, rs2, rs1, 3'b111, rd, OPC_OP);
      OP_LB     : word = enc_i(rvimm[11:0], rs1, 3'b000, rd, OPC_LOAD);
      OP_LH     : word = enc_i(rvimm[11:0], rs1, 3'b001, rd, OPC_LOAD);
      OP_LW     : word = enc_i(rvimm[11:0], rs1, 3'b010, rd, OPC_LOAD);
      OP_LBU    : word = enc_i(rvimm[11:0], rs1, 3'b100, rd, OPC_LOAD);
      OP_LHU    : word = enc_i(rvimm[11:0], rs1, 3'b101, rd, OPC_LOAD);
      OP_SB     : word = enc_s(rvimm[11:0], rs2, rs1, 3'b000);
      OP_SH     : word = enc_s(rvimm[11:0], rs2, rs1, 3'b001);
      OP_SW     : word = enc_s(rvimm[11:0], rs2, rs1, 3'b010);
      OP_LUI    : word = enc_u(rvimm[31:12], rd, OPC_LUI);
      OP_AUIPC  : word = enc_u(off[31:12], rd, OPC_AUIPC);
      OP_BEQ    : begin word = enc_b(off[12:1], rs2, rs1, 3'b000); range_bad = br_bad; end
      OP_BNE    : begin word = enc_b(off[12:1], rs2, rs1, 3'b001); range_bad = br_bad; end
      OP_BLT    : begin word = enc_b(off[12:1], rs2, rs1, 3'b100); range_bad = br_bad; end
      OP_BGE    : begin word = enc_b(off[12:1], rs2, rs1, 3'b101); range_bad = br_bad; end
      OP_BLTU   : begin word = enc_b(off[12:1], rs2, rs1, 3'b110); range_bad = br_bad; end
      OP_BGEU   : begin word = enc_b(off[12:1], rs2, rs1, 3'b111); range_bad = br_bad; end
      OP_JAL    : begin word = enc_j(off[20:1], rd);   range_bad = jal_bad; end
      OP_J      : begin word = enc_j(off[20:1], 5'd0); range_bad = jal_bad; end
      OP_JALR   : word = enc_i(rvimm[11:0], rs1, 3'b000, rd,   OPC_JALR);
      OP_JR     : word = enc_i(rvimm[11:0], rs1, 3'b000, 5'd0, OPC_JALR);
      OP_RET    : word = enc_i(12'd0,       rs1, 3'b000, 5'd0, OPC_JALR);
      OP_NOP    : word = INSN_NOP;
      OP_BREAK  : word = INSN_BREAK;
      OP_MONITOR: word = INSN_MONITOR;
      OP_RDCYCLE   : word = enc_i(CSR_CYCLE,    5'd0, 3'b010, rd, OPC_SYS);
      OP_RDCYCLEH  : word = enc_i(CSR_CYCLEH,   5'd0, 3'b010, rd, OPC_SYS);
      OP_RDINSTRET : word = enc_i(CSR_INSTRET,  5'd0, 3'b010, rd, OPC_SYS);
      OP_RDINSTRETH: word = enc_i(CSR_INSTRETH, 5'd0, 3'b010, rd, OPC_SYS);
      default   : unk = 1'b1;
    endcase
  end

  assign bad  = unk | range_bad;
  assign insn = bad ? '0 : word;

endmodule

// File: rtl/retire_insn_encoder.sv
// retire_insn_encoder: re-encodes retired uops into canonical RV32IM words and
// queues them (with their PC) in a DEPTH-entry FIFO for the co-sim checker.
//   clk, reset_n (async, active-low)
//   in_valid/in_ready + in_op/in_dst/in_srcA/in_srcB/in_rvimm/in_pc : commit side
//   out_valid/out_ready + out_insn/out_pc/out_bad                  : trace side
// Optional: define ENC_ERR_COUNT_EN to add err_count (saturating count of bad
// pushes) and err_sticky (set on first bad push, cleared only by reset).
module retire_insn_encoder
  import retire_insn_encoder_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LG_DEPTH = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  opcode_t                     in_op,
  input  logic [LG_PRF_ENTRIES-1:0]   in_dst,
  input  logic [LG_PRF_ENTRIES-1:0]   in_srcA,
  input  logic [LG_PRF_ENTRIES-1:0]   in_srcB,
  input  logic [31:0]                 in_rvimm,
  input  logic [M_WIDTH-1:0]          in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_insn,
  output logic [M_WIDTH-1:0]          out_pc,
  output logic                        out_bad
`ifdef ENC_ERR_COUNT_EN
  ,
  output logic [31:0]                 err_count,
  output logic                        err_sticky
`endif
);

  localparam logic [LG_DEPTH:0] CNT_FULL = (LG_DEPTH+1)'(DEPTH);

  logic [31:0]         enc_insn;
  logic                enc_bad;
  logic [31:0]         insn_mem [DEPTH];
  logic [M_WIDTH-1:0]  pc_mem   [DEPTH];
  logic [DEPTH-1:0]    bad_mem;
  logic [LG_DEPTH-1:0] rd_ptr;
  logic [LG_DEPTH-1:0] wr_ptr;
  logic [LG_DEPTH:0]   count;
  logic                push;
  logic                pop;
  logic                unused_prf_hi;

  // Only the architectural part of the register indices is encoded.
  assign unused_prf_hi = ^{in_dst[LG_PRF_ENTRIES-1:5], in_srcA[LG_PRF_ENTRIES-1:5],
                           in_srcB[LG_PRF_ENTRIES-1:5]};

  rv_insn_pack u_pack (
    .op    (in_op),
    .rd    (in_dst[4:0]),
    .rs1   (in_srcA[4:0]),
    .rs2   (in_srcB[4:0]),
    .rvimm (in_rvimm),
    .pc    (in_pc),
    .insn  (enc_insn),
    .bad   (enc_bad)
  );

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_ready  = (count < CNT_FULL) | pop;
  assign push      = in_valid & in_ready;

  // Head fields are masked so a reset (async count clear) zeroes them at once.
  assign out_insn = out_valid ? insn_mem[rd_ptr] : '0;
  assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
  assign out_bad  = out_valid & bad_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem[wr_ptr] <= enc_insn;
      pc_mem[wr_ptr]   <= in_pc;
      bad_mem[wr_ptr]  <= enc_bad;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LG_DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + LG_DEPTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (LG_DEPTH+1)'(1);
        2'b01:   count <= count - (LG_DEPTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ENC_ERR_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (push && enc_bad) begin
      if (err_count != '1) err_count <= err_count + 32'd1;
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_retire_insn_encoder.sv
// Self-checking bench for retire_insn_encoder: directed encodings, FIFO
// full/hold/drain behaviour, asynchronous reset mid-drain, then random traffic
// against a queue-based reference model.
module tb_retire_insn_encoder;
  import retire_insn_encoder_pkg::*;

  localparam int DEPTH = 4;

  localparam int OPIMM_F3[6]  = '{0, 2, 3, 4, 6, 7};
  localparam int ROP_F3[10]   = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  localparam int ROP_F7[10]   = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
  localparam int LOAD_F3[5]   = '{0, 1, 2, 4, 5};
  localparam int BR_F3[6]     = '{0, 1, 4, 5, 6, 7};
  localparam int CSR_NUM[4]   = '{'hC00, 'hC80, 'hC02, 'hC82};

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      in_valid;
  logic                      in_ready;
  opcode_t                   in_op;
  logic [LG_PRF_ENTRIES-1:0] in_dst, in_srcA, in_srcB;
  logic [31:0]               in_rvimm;
  logic [M_WIDTH-1:0]        in_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_insn;
  logic [M_WIDTH-1:0]        out_pc;
  logic                      out_bad;
`ifdef ENC_ERR_COUNT_EN
  logic [31:0]               err_count;
  logic                      err_sticky;
`endif

  retire_insn_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_dst    (in_dst),
    .in_srcA   (in_srcA),
    .in_srcB   (in_srcB),
    .in_rvimm  (in_rvimm),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_pc    (out_pc),
    .out_bad   (out_bad)
`ifdef ENC_ERR_COUNT_EN
    ,
    .err_count (err_count),
    .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        bad;
  } ent_t;

  ent_t        q[$];
  int          n_asserts = 0;
  int          n_fail    = 0;
  int unsigned m_err_cnt = 0;
  logic        m_err_sticky = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder built directly from the RV32 field layouts.
  function automatic ent_t ref_encode(input opcode_t op, input logic [5:0] d6,
                                      input logic [5:0] a6, input logic [5:0] b6,
                                      input logic [31:0] imm, input logic [31:0] pc);
    logic [31:0] rd, rs1, rs2, w, uoff, f3, f7;
    int          off, k;
    logic        bad;
    ent_t        e;
    rd   = 32'(d6 & 6'd31);
    rs1  = 32'(a6 & 6'd31);
    rs2  = 32'(b6 & 6'd31);
    uoff = imm - pc;
    off  = int'(uoff);
    k    = int'(op);
    w    = 0;
    bad  = 1'b0;
    if (k >= int'(OP_ADDI) && k <= int'(OP_ANDI)) begin
      f3 = 32'(OPIMM_F3[k - int'(OP_ADDI)]);
      w  = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
    end else if (k >= int'(OP_SLLI) && k <= int'(OP_SRAI)) begin
      f3 = (op == OP_SLLI) ? 1 : 5;
      f7 = (op == OP_SRAI) ? 32 : 0;
      w  = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
    end else if (k >= int'(OP_ADD) && k <= int'(OP_AND)) begin
      f3 = 32'(ROP_F3[k - int'(OP_ADD)]);
      f7 = 32'(ROP_F7[k - int'(OP_ADD)]);
      w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    end else if (k >= int'(OP_MUL) && k <= int'(OP_REMU)) begin
      f3 = 32'(k - int'(OP_MUL));
      w  = (32'd1 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    end else if (k >= int'(OP_LB) && k <= int'(OP_LHU)) begin
      f3 = 32'(LOAD_F3[k - int'(OP_LB)]);
      w  = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
    end else if (k >= int'(OP_SB) && k <= int'(OP_SW)) begin
      f3 = 32'(k - int'(OP_SB));
      w  = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
         | ((imm & 31) << 7) | 32'h23;
    end else if (op == OP_LUI) begin
      w = (imm & 32'hfffff000) | (rd << 7) | 32'h37;
    end else if (op == OP_AUIPC) begin
      w = (uoff & 32'hfffff000) | (rd << 7) | 32'h17;
    end else if (k >= int'(OP_BEQ) && k <= int'(OP_BGEU)) begin
      f3 = 32'(BR_F3[k - int'(OP_BEQ)]);
      if (off < -4096 || off > 4095 || (off % 2) != 0) bad = 1'b1;
      else w = (((uoff >> 12) & 1) << 31) | (((uoff >> 5) & 63) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((uoff >> 1) & 15) << 8)
             | (((uoff >> 11) & 1) << 7) | 32'h63;
    end else if (op == OP_JAL || op == OP_J) begin
      if (op == OP_J) rd = 0;
      if (off < -1048576 || off > 1048575 || (off % 2) != 0) bad = 1'b1;
      else w = (((uoff >> 20) & 1) << 31) | (((uoff >> 1) & 32'h3ff) << 21)
             | (((uoff >> 11) & 1) << 20) | (((uoff >> 12) & 32'hff) << 12)
             | (rd << 7) | 32'h6f;
    end else if (op == OP_JALR) begin
      w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
    end else if (op == OP_JR) begin
      w = ((imm & 32'hfff) << 20) | (rs1 << 15) | 32'h67;
    end else if (op == OP_RET) begin
      w = (rs1 << 15) | 32'h67;
    end else if (op == OP_NOP) begin
      w = 32'h13;
    end else if (op == OP_BREAK) begin
      w = 32'h73;
    end else if (op == OP_MONITOR) begin
      w = 32'h00100073;
    end else if (k >= int'(OP_RDCYCLE) && k <= int'(OP_RDINSTRETH)) begin
      w = (32'(CSR_NUM[k - int'(OP_RDCYCLE)]) << 20) | (32'd2 << 12) | (rd << 7) | 32'h73;
    end else begin
      bad = 1'b1;
    end
    if (bad) w = 0;
    e.insn = w;
    e.pc   = pc;
    e.bad  = bad;
    return e;
  endfunction

  // One clock of traffic: drive after the falling edge, check, then update the model.
  task automatic step(input logic v, input opcode_t op, input logic [5:0] d,
                      input logic [5:0] a, input logic [5:0] b,
                      input logic [31:0] imm, input logic [31:0] pc, input logic ordy);
    logic exp_rdy;
    ent_t e;
    @(negedge clk);
    in_valid = v;  in_op = op; in_dst = d; in_srcA = a; in_srcB = b;
    in_rvimm = imm; in_pc = pc; out_ready = ordy;
    #1;
    exp_rdy = (q.size() < DEPTH) || (q.size() != 0 && ordy);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_insn", out_insn, q[0].insn);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_bad", out_bad, q[0].bad);
    end
`ifdef ENC_ERR_COUNT_EN
    chk("err_count", err_count, m_err_cnt);
    chk("err_sticky", err_sticky, m_err_sticky);
`endif
    @(posedge clk);
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (v && exp_rdy) begin
      e = ref_encode(op, d, a, b, imm, pc);
      q.push_back(e);
      if (e.bad) begin
        if (m_err_cnt != 32'hFFFFFFFF) m_err_cnt++;
        m_err_sticky = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, OP_NOP, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, ordy);
  endtask

  initial begin
    logic [31:0] pc, imm;
    int          r;
    reset_n = 1'b0; in_valid = 1'b0; in_op = OP_NOP; in_dst = '0; in_srcA = '0;
    in_srcB = '0; in_rvimm = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_insn", out_insn, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_bad", out_bad, 1'b0);
`ifdef ENC_ERR_COUNT_EN
    chk("rst_err_count", err_count, 32'd0);
    chk("rst_err_sticky", err_sticky, 1'b0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b1);

    // Directed encodings, one entry in flight at a time.
    step(1'b1, OP_ADDI, 6'd5, 6'd6, 6'd0, 32'hFFFFFFFF, 32'h100, 1'b1);
    #2; chk("addi_insn", out_insn, 32'hFFF30293); chk("addi_bad", out_bad, 1'b0);
    step(1'b1, OP_BEQ, 6'd0, 6'd1, 6'd2, 32'h00000FF8, 32'h1000, 1'b1);
    #2; chk("beq_insn", out_insn, 32'hFE208CE3); chk("beq_pc", out_pc, 32'h1000);
    step(1'b1, OP_RET, 6'd0, 6'd1, 6'd0, 32'd0, 32'h2000, 1'b1);
    #2; chk("ret_insn", out_insn, 32'h00008067);
    step(1'b1, OP_LUI, 6'd10, 6'd0, 6'd0, 32'h12345000, 32'h2004, 1'b1);
    #2; chk("lui_insn", out_insn, 32'h12345537);
    step(1'b1, OP_BEQ, 6'd0, 6'd1, 6'd2, 32'h00002000, 32'h0, 1'b1);
    #2; chk("beq_far_insn", out_insn, 32'd0); chk("beq_far_bad", out_bad, 1'b1);
`ifdef ENC_ERR_COUNT_EN
    chk("beq_far_errcnt", err_count, 32'd1);
`endif
    idle(1'b1);

    // Fill with the consumer stalled; fifth push must be held.
    for (int i = 1; i <= 4; i++)
      step(1'b1, OP_ADDI, 6'(i), 6'd1, 6'd0, 32'(i), 32'(32'h3000 + 4 * i), 1'b0);
    #2; chk("full_in_ready", in_ready, 1'b0);
    step(1'b1, OP_ADDI, 6'd5, 6'd1, 6'd0, 32'd5, 32'h3014, 1'b0);
    step(1'b1, OP_ADDI, 6'd5, 6'd1, 6'd0, 32'd5, 32'h3014, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset with entries still queued.
    @(negedge clk);
    in_valid = 1'b0;
    #2; chk("pre_rst_valid", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_insn", out_insn, 32'd0);
    q.delete();
    m_err_cnt = 0;
    m_err_sticky = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b1);

    // Random traffic, including out-of-range targets and unknown opcodes.
    for (int n = 0; n < 500; n++) begin
      pc = $urandom & 32'hFFFFFFFC;
      r  = int'($urandom_range(0, 3));
      case (r)
        0:       imm = $urandom;
        1:       imm = pc + 32'(int'($urandom_range(0, 12000)) - 6000);
        2:       imm = pc + (32'(int'($urandom_range(0, 4000000)) - 2000000) & 32'hFFFFFFFE);
        default: imm = pc + (32'(int'($urandom_range(0, 9000)) - 4500) & 32'hFFFFFFFE);
      endcase
      step(($urandom % 4) != 0, opcode_t'($urandom_range(0, 63)), 6'($urandom),
           6'($urandom), 6'($urandom), imm, pc, ($urandom % 3) != 0);
    end
    for (int n = 0; n < DEPTH + 1; n++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
